// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and single-outstanding imem port.
// Stale responses are discarded after a redirect; hazard freezes are counted.
module fetch_stage #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic                   fetch_wait,
  output logic [CNT_WIDTH-1:0]   freeze_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  active;
  logic                  consume;

  assign pc_next = pc + ADDR_WIDTH'(PC_STEP);
  assign active  = (state != IDLE);
  assign consume = (state == FETCH) && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (!imem_ready && branch_taken) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_ready) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = active;
    fetch_wait = active && !imem_ready;
  end

  // pc and imem_addr diverge only in DROP, where pc holds the redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          pc        <= pc;
          imem_addr <= imem_addr;
        end
        FETCH: begin
          if (branch_taken) begin
            pc <= branch_addr;
            if (imem_ready) begin
              imem_addr <= branch_addr;
            end
          end else if (!hazard && imem_ready) begin
            pc        <= pc_next;
            imem_addr <= pc_next;
          end
        end
        DROP: begin
          if (branch_taken) begin
            pc <= branch_addr;
          end
          if (imem_ready) begin
            imem_addr <= branch_taken ? branch_addr : pc;
          end
        end
        default: begin
          pc        <= RESET_PC;
          imem_addr <= RESET_PC;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (active) begin
      if (branch_taken) begin
        if_id_pc    <= '0;
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end else if (hazard) begin
        if_id_pc    <= if_id_pc;
        if_id_instr <= if_id_instr;
        if_id_valid <= if_id_valid;
      end else if (consume) begin
        if_id_pc    <= pc_next;
        if_id_instr <= imem_rdata;
        if_id_valid <= 1'b1;
      end else begin
        if_id_pc    <= '0;
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_cnt <= '0;
    end else if (active && hazard && !branch_taken
                 && freeze_cnt != '1) begin
      freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory returns addr|0xA0000000 whenever imem_ready is high.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_wait;
  logic [15:0] freeze_cnt;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_wait   (fetch_wait),
    .freeze_cnt   (freeze_cnt)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'hA000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0;
    branch_addr = '0; imem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_req: got req=%b addr=%h want 0 0",
               imem_req, imem_addr);
    end
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr, freeze_cnt}
        !== {1'b0, 32'h0, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_ifid: got v=%b pc=%h i=%h cnt=%h want zeros",
               if_id_valid, if_id_pc, if_id_instr, freeze_cnt);
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL seq_first_req: got req=%b addr=%h v=%b want 1 0 0",
               imem_req, imem_addr, if_id_valid);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instr, imem_addr}
          !== {1'b1, 32'(4 * k), 32'hA000_0000 + 32'(4 * (k - 1)),
               32'(4 * k)}) begin
        errors++;
        $display("FAIL seq_fetch%0d: got v=%b pc=%h i=%h a=%h", k,
                 if_id_valid, if_id_pc, if_id_instr, imem_addr);
      end
    end
  endtask

  task automatic test_hazard();
    hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({imem_addr, if_id_valid, if_id_pc, if_id_instr}
          !== {32'h8, 1'b1, 32'h8, 32'hA000_0004}) begin
        errors++;
        $display("FAIL hazard_hold%0d: got a=%h v=%b pc=%h i=%h", k,
                 imem_addr, if_id_valid, if_id_pc, if_id_instr);
      end
    end
    hazard = 1'b0;
    tick();
    checks++;
    if ({if_id_pc, if_id_instr, imem_addr, freeze_cnt}
        !== {32'hC, 32'hA000_0008, 32'hC, 16'd2}) begin
      errors++;
      $display("FAIL hazard_release: got pc=%h i=%h a=%h cnt=%0d want c a0000008 c 2",
               if_id_pc, if_id_instr, imem_addr, freeze_cnt);
    end
    tick();
    checks++;
    if ({if_id_pc, imem_addr} !== {32'h10, 32'h10}) begin
      errors++;
      $display("FAIL hazard_next: got pc=%h a=%h want 10 10",
               if_id_pc, imem_addr);
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({fetch_wait, if_id_valid, if_id_instr, imem_addr}
          !== {1'b1, 1'b0, 32'h0, 32'h10}) begin
        errors++;
        $display("FAIL wait%0d: got w=%b v=%b i=%h a=%h want 1 0 0 10",
                 k, fetch_wait, if_id_valid, if_id_instr, imem_addr);
      end
    end
  endtask

  task automatic test_branch_drop();
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    checks++;
    if ({imem_req, fetch_wait, imem_addr, if_id_valid, if_id_pc}
        !== {1'b1, 1'b1, 32'h10, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL drop_enter: got req=%b w=%b a=%h v=%b pc=%h",
               imem_req, fetch_wait, imem_addr, if_id_valid, if_id_pc);
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr}
        !== {32'h100, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL drop_discard: got a=%h v=%b i=%h want 100 0 0",
               imem_addr, if_id_valid, if_id_instr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr, imem_addr}
        !== {1'b1, 32'h104, 32'hA000_0100, 32'h104}) begin
      errors++;
      $display("FAIL drop_target: got v=%b pc=%h i=%h a=%h",
               if_id_valid, if_id_pc, if_id_instr, imem_addr);
    end
  endtask

  task automatic test_branch_vs_hazard();
    hazard = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
    tick();
    hazard = 1'b0; branch_taken = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr, imem_addr, freeze_cnt}
        !== {1'b0, 32'h0, 32'h0, 32'h200, 16'd2}) begin
      errors++;
      $display("FAIL branch_wins: got v=%b pc=%h i=%h a=%h cnt=%0d",
               if_id_valid, if_id_pc, if_id_instr, imem_addr, freeze_cnt);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, 32'h204}) begin
      errors++;
      $display("FAIL branch_resume: got v=%b pc=%h want 1 204",
               if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr, imem_addr}
        !== {1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL pc_wrap: got v=%b pc=%h i=%h a=%h",
               if_id_valid, if_id_pc, if_id_instr, imem_addr);
    end
  endtask

  task automatic test_saturate();
    hazard = 1'b1;
    for (int k = 0; k < 65532; k++) tick();
    checks++;
    if (freeze_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_below: got %h want fffe", freeze_cnt);
    end
    tick();
    checks++;
    if (freeze_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_top: got %h want ffff", freeze_cnt);
    end
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (freeze_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", freeze_cnt);
    end
    hazard = 1'b0;
  endtask

  task automatic test_reset_in_drop();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h300;
    tick();
    branch_taken = 1'b0;
    rst = 1'b1; imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req, fetch_wait, imem_addr, if_id_valid, if_id_pc,
         if_id_instr, freeze_cnt}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL rst_drop: got req=%b w=%b a=%h v=%b pc=%h i=%h cnt=%h",
               imem_req, fetch_wait, imem_addr, if_id_valid, if_id_pc,
               if_id_instr, freeze_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_restart: got req=%b a=%h v=%b want 1 0 0",
               imem_req, imem_addr, if_id_valid);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr}
        !== {1'b1, 32'h4, 32'hA000_0000}) begin
      errors++;
      $display("FAIL rst_first: got v=%b pc=%h i=%h want 1 4 a0000000",
               if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hazard();
    test_wait();
    test_branch_drop();
    test_branch_vs_hazard();
    test_wrap();
    test_saturate();
    test_reset_in_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
